bcd_multi_timer: RTL and testbench



---
 rtl/bcd_multi_timer.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_bcd_multi_timer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_multi_timer.sv
// Multi-channel MM:SS BCD countdown timer with a shared 1 s prescaler and a scanned 4-digit display.
// Optional egg presets are compiled in when EGG_PRESET_EN is defined.
module bcd_multi_timer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned SCAN_DIV  = 10000,
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic              clk_5MHz,
    input  logic              reset,
    input  logic [1:0]        sel,
    input  logic              inc_min,
    input  logic              inc_sec,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
`ifdef EGG_PRESET_EN
    input  logic [1:0]        preset,
    input  logic              preset_ld,
`endif
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] alarm,
    output logic [7:0]        an,
    output logic [7:0]        seg
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned ACNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] m_tens;
        logic [3:0] m_ones;
        logic [2:0] s_tens;
        logic [3:0] s_ones;
    } bcd_time_t;

    // One-second decrement with the BCD borrow chain.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_ones != 4'd0) begin
            r.s_ones = t.s_ones - 4'd1;
        end else begin
            r.s_ones = 4'd9;
            if (t.s_tens != 3'd0) begin
                r.s_tens = t.s_tens - 3'd1;
            end else begin
                r.s_tens = 3'd5;
                if (t.m_ones != 4'd0) begin
                    r.m_ones = t.m_ones - 4'd1;
                end else begin
                    r.m_ones = 4'd9;
                    r.m_tens = t.m_tens - 3'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bump_sec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s_ones == 4'd9) begin
            r.s_ones = 4'd0;
            r.s_tens = (t.s_tens == 3'd5) ? 3'd0 : t.s_tens + 3'd1;
        end else begin
            r.s_ones = t.s_ones + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd_time_t bump_min(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m_ones == 4'd9) begin
            r.m_ones = 4'd0;
            r.m_tens = (t.m_tens == 3'd5) ? 3'd0 : t.m_tens + 3'd1;
        end else begin
            r.m_ones = t.m_ones + 4'd1;
        end
        return r;
    endfunction

`ifdef EGG_PRESET_EN
    function automatic bcd_time_t preset_time(input logic [1:0] p);
        bcd_time_t r;
        r = '0;
        case (p)
            2'd0:    r.m_ones = 4'd6;
            2'd1:    r.m_ones = 4'd8;
            2'd2:    begin r.m_tens = 3'd1; r.m_ones = 4'd3; end
            default: r.m_ones = 4'd3;
        endcase
        return r;
    endfunction
`endif

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Shared 1 s prescaler
    logic [TICK_W-1:0] presc_q;
    logic              tick_c;

    assign tick_c = (presc_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick_c) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
        end
    end

    // Command addressing; out-of-range sel addresses nobody
    logic              sel_ok_c;
    logic [NUM_CH-1:0] hit_c;

    assign sel_ok_c = (32'(sel) < NUM_CH);

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit_c[i] = sel_ok_c && (sel == 2'(i));
        end
    end

    state_t            st_q   [NUM_CH];
    state_t            st_d   [NUM_CH];
    bcd_time_t         tm_q   [NUM_CH];
    bcd_time_t         tm_d   [NUM_CH];
    logic [ACNT_W-1:0] ac_q   [NUM_CH];
    logic [ACNT_W-1:0] ac_d   [NUM_CH];
    logic [NUM_CH-1:0] done_d;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] alarm_d;

    // Channel state and output registers
    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                st_q[i] <= ST_IDLE;
                tm_q[i] <= '0;
                ac_q[i] <= '0;
            end
            busy  <= '0;
            done  <= '0;
            alarm <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                st_q[i] <= st_d[i];
                tm_q[i] <= tm_d[i];
                ac_q[i] <= ac_d[i];
            end
            busy  <= busy_d;
            done  <= done_d;
            alarm <= alarm_d;
        end
    end

    // Next state: highest-priority command first; an acting clear/pause pre-empts the tick
    always_comb begin
        logic held;
        logic edit;
        held   = 1'b0;
        edit   = 1'b0;
        done_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            st_d[i] = st_q[i];
            tm_d[i] = tm_q[i];
            ac_d[i] = ac_q[i];
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            held = 1'b0;
            edit = (st_q[i] == ST_IDLE) || (st_q[i] == ST_PAUSE);
            if (hit_c[i]) begin
                if (clear) begin
                    st_d[i] = ST_IDLE;
                    tm_d[i] = '0;
                    ac_d[i] = '0;
                    held    = 1'b1;
                end else if (start) begin
                    if (edit && (tm_q[i] != '0)) begin
                        st_d[i] = ST_RUN;
                    end
                end else if (pause) begin
                    if (st_q[i] == ST_RUN) begin
                        st_d[i] = ST_PAUSE;
                        held    = 1'b1;
                    end
                end
`ifdef EGG_PRESET_EN
                else if (preset_ld) begin
                    if (edit) begin
                        tm_d[i] = preset_time(preset);
                    end
                end
`endif
                else if (inc_min) begin
                    if (edit) begin
                        tm_d[i] = bump_min(tm_q[i]);
                    end
                end else if (inc_sec) begin
                    if (edit) begin
                        tm_d[i] = bump_sec(tm_q[i]);
                    end
                end
            end
            if (tick_c && !held) begin
                if (st_q[i] == ST_RUN) begin
                    tm_d[i] = bcd_dec(tm_q[i]);
                    if (bcd_dec(tm_q[i]) == '0) begin
                        st_d[i]   = ST_ALARM;
                        ac_d[i]   = '0;
                        done_d[i] = 1'b1;
                    end
                end else if (st_q[i] == ST_ALARM) begin
                    if (ac_q[i] == ACNT_W'(ALARM_SEC - 1)) begin
                        st_d[i] = ST_IDLE;
                        ac_d[i] = '0;
                    end else begin
                        ac_d[i] = ac_q[i] + ACNT_W'(1);
                    end
                end
            end
        end
    end

    // Status outputs follow the next state so they line up with the state register
    always_comb begin
        busy_d  = '0;
        alarm_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            busy_d[i]  = (st_d[i] == ST_RUN) || (st_d[i] == ST_PAUSE);
            alarm_d[i] = (st_d[i] == ST_ALARM);
        end
    end

    // Display scan
    logic [SCAN_W-1:0] scan_q;
    logic [1:0]        idx_q;
    logic              step_c;
    bcd_time_t         d_tm_c;
    state_t            d_st_c;
    logic              d_odd_c;
    logic [3:0]        digit_c;
    logic [7:0]        an_c;
    logic [7:0]        seg_c;

    assign step_c = (scan_q == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        d_tm_c  = tm_q[0];
        d_st_c  = st_q[0];
        d_odd_c = ac_q[0][0];
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (hit_c[i]) begin
                d_tm_c  = tm_q[i];
                d_st_c  = st_q[i];
                d_odd_c = ac_q[i][0];
            end
        end
        case (idx_q)
            2'd0:    begin an_c = 8'hF7; digit_c = {1'b0, d_tm_c.m_tens}; end
            2'd1:    begin an_c = 8'hFB; digit_c = d_tm_c.m_ones;         end
            2'd2:    begin an_c = 8'hFD; digit_c = {1'b0, d_tm_c.s_tens}; end
            default: begin an_c = 8'hFE; digit_c = d_tm_c.s_ones;         end
        endcase
        seg_c = seg_decode(digit_c);
        if ((idx_q == 2'd1) && (d_st_c == ST_RUN)) begin
            seg_c[7] = 1'b0;
        end
        if ((d_st_c == ST_ALARM) && !d_odd_c) begin
            seg_c = 8'hFF;
        end
    end

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
            an     <= 8'hFF;
            seg    <= 8'hFF;
        end else if (step_c) begin
            scan_q <= '0;
            idx_q  <= idx_q + 2'd1;
            an     <= an_c;
            seg    <= seg_c;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
        end
    end

endmodule

// File: tb/tb_bcd_multi_timer.sv
// Directed self-checking bench for bcd_multi_timer; values are read back through the scanned display.
module tb_bcd_multi_timer;

    localparam int TICK_DIV = 10;
    localparam int SCAN_DIV = 4;

    logic       clk_5MHz = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] sel      = 2'd0;
    logic       inc_min  = 1'b0;
    logic       inc_sec  = 1'b0;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       clear    = 1'b0;
`ifdef EGG_PRESET_EN
    logic [1:0] preset    = 2'd0;
    logic       preset_ld = 1'b0;
`endif
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] alarm;
    logic [7:0] an;
    logic [7:0] seg;

    int passes   = 0;
    int total    = 0;
    int pc       = 0;
    int tick_cnt = 0;

    bcd_multi_timer #(
        .NUM_CH   (2),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .ALARM_SEC(5)
    ) dut (
        .clk_5MHz (clk_5MHz),
        .reset    (reset),
        .sel      (sel),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
`ifdef EGG_PRESET_EN
        .preset   (preset),
        .preset_ld(preset_ld),
`endif
        .busy     (busy),
        .done     (done),
        .alarm    (alarm),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    // Reference 1 s tick: tick edges are the posedges where pc == TICK_DIV-1
    always @(posedge clk_5MHz or posedge reset) begin
        if (reset) pc <= 0;
        else       pc <= (pc == TICK_DIV - 1) ? 0 : pc + 1;
    end

    always @(posedge clk_5MHz) begin
        if (!reset && pc == TICK_DIV - 1) tick_cnt <= tick_cnt + 1;
    end

    function automatic logic [7:0] seg7(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] disp(input int mm, input int ss);
        return {seg7(mm / 10), seg7(mm % 10), seg7(ss / 10), seg7(ss % 10)};
    endfunction

    function automatic logic [7:0] next_an(input logic [7:0] a);
        case (a)
            8'hF7:   return 8'hFB;
            8'hFB:   return 8'hFD;
            8'hFD:   return 8'hFE;
            default: return 8'hF7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // 0 clear, 1 start, 2 pause, 3 inc_min, 4 inc_sec, 5 preset_ld
    task automatic pulse_cmd(input int c);
        @(negedge clk_5MHz);
        case (c)
            0: clear   = 1'b1;
            1: start   = 1'b1;
            2: pause   = 1'b1;
            3: inc_min = 1'b1;
            4: inc_sec = 1'b1;
`ifdef EGG_PRESET_EN
            5: preset_ld = 1'b1;
`endif
            default: ;
        endcase
        @(negedge clk_5MHz);
        clear = 1'b0; start = 1'b0; pause = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
`ifdef EGG_PRESET_EN
        preset_ld = 1'b0;
`endif
    endtask

    task automatic wait_ticks(input int n);
        int snap;
        snap = tick_cnt;
        for (int i = 0; i < n * TICK_DIV + 2 && tick_cnt < snap + n; i++) @(negedge clk_5MHz);
    endtask

    // Capture {m_tens, m_ones, s_tens, s_ones} segment patterns of the displayed channel
    task automatic read_disp(output logic [31:0] d);
        logic [3:0] got;
        got = 4'h0;
        d   = 32'hFFFF_FFFF;
        repeat (4 * SCAN_DIV + 2) @(negedge clk_5MHz);
        for (int i = 0; i < 6 * SCAN_DIV; i++) begin
            @(negedge clk_5MHz);
            case (an)
                8'hF7: begin d[31:24] = seg; got[3] = 1'b1; end
                8'hFB: begin d[23:16] = seg; got[2] = 1'b1; end
                8'hFD: begin d[15:8]  = seg; got[1] = 1'b1; end
                8'hFE: begin d[7:0]   = seg; got[0] = 1'b1; end
                default: ;
            endcase
        end
        chk("scan_cover", 32'(got), 32'hF);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  an_prev;
        int          e;
        int          k;
        int          s1r;
        int          snap;
        int          tc_prev;

        // Reset values
        repeat (3) @(negedge clk_5MHz);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_alarm", 32'(alarm), 32'h0);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        reset = 1'b0;
        read_disp(d);
        chk("idle_0000", d, disp(0, 0));

        // Channel 0: 00:03 countdown, expiry, alarm blink and hold
        sel = 2'd0;
        repeat (3) pulse_cmd(4);
        read_disp(d);
        chk("set_0003", d, disp(0, 3));
        pulse_cmd(1);
        chk("run_busy", 32'(busy), 32'h1);
        wait_ticks(2);
        chk("cd_busy", 32'(busy), 32'h1);
        chk("cd_nodone", 32'(done), 32'h0);
        wait_ticks(1);
        chk("exp_done", 32'(done), 32'h1);
        chk("exp_alarm", 32'(alarm), 32'h1);
        chk("exp_busy", 32'(busy), 32'h0);
        @(negedge clk_5MHz);
        chk("done_1cyc", 32'(done), 32'h0);
        repeat (4) @(negedge clk_5MHz);
        chk("blink_blank", 32'(seg), 32'hFF);
        wait_ticks(1);
        repeat (5) @(negedge clk_5MHz);
        chk("blink_show", 32'(seg), 32'hC0);
        wait_ticks(3);
        chk("alarm_hold", 32'(alarm), 32'h1);
        wait_ticks(1);
        chk("alarm_end", 32'(alarm), 32'h0);
        chk("alarm_end_busy", 32'(busy), 32'h0);

        // Two channels: minute borrow on ch1 while ch0 expires
        sel = 2'd1;
        pulse_cmd(3);
        pulse_cmd(1);
        wait_ticks(1);
        pulse_cmd(2);
        chk("ch1_paused_busy", 32'(busy), 32'h2);
        read_disp(d);
        chk("ch1_borrow_0059", d, disp(0, 59));
        pulse_cmd(1);
        s1r = tick_cnt;
        sel = 2'd0;
        repeat (2) pulse_cmd(4);
        pulse_cmd(1);
        wait_ticks(1);
        chk("both_busy", 32'(busy), 32'h3);
        chk("both_nodone", 32'(done), 32'h0);
        wait_ticks(1);
        chk("ch0_done_only", 32'(done), 32'h1);
        chk("ch0_alarm_only", 32'(alarm), 32'h1);
        chk("ch1_still_busy", 32'(busy), 32'h2);
        sel = 2'd1;
        e = tick_cnt;
        pause = 1'b1;
        @(negedge clk_5MHz);
        pause = 1'b0;
        k = e - s1r;
        read_disp(d);
        chk("ch1_shared_ticks", d, disp(0, 59 - k));
        pulse_cmd(0);
        sel = 2'd0;
        pulse_cmd(0);
        chk("clear_alarm", 32'(alarm), 32'h0);
        chk("clear_busy", 32'(busy), 32'h0);

        // Pause on the tick cycle wins over the decrement
        repeat (6) pulse_cmd(4);
        pulse_cmd(1);
        wait_ticks(1);
        for (int i = 0; i < TICK_DIV + 2 && pc != TICK_DIV - 1; i++) @(negedge clk_5MHz);
        pause = 1'b1;
        @(negedge clk_5MHz);
        pause = 1'b0;
        chk("pause_tick_busy", 32'(busy), 32'h1);
        read_disp(d);
        chk("pause_tick_0005", d, disp(0, 5));
        pulse_cmd(1);
        wait_ticks(1);
        pulse_cmd(2);
        read_disp(d);
        chk("resume_0004", d, disp(0, 4));
        @(negedge clk_5MHz);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk_5MHz);
        clear = 1'b0;
        start = 1'b0;
        chk("clr_start_busy", 32'(busy), 32'h0);
        read_disp(d);
        chk("clr_start_0000", d, disp(0, 0));

        // Edit wrap rules, start at 00:00, out-of-range sel
        repeat (2) pulse_cmd(3);
        repeat (60) pulse_cmd(4);
        read_disp(d);
        chk("sec_wrap_0200", d, disp(2, 0));
        repeat (58) pulse_cmd(3);
        read_disp(d);
        chk("min_wrap_0000", d, disp(0, 0));
        pulse_cmd(1);
        chk("start_zero_busy", 32'(busy), 32'h0);
        pulse_cmd(4);
        sel = 2'd3;
        pulse_cmd(4);
        pulse_cmd(3);
        pulse_cmd(1);
        chk("sel3_busy", 32'(busy), 32'h0);
        read_disp(d);
        chk("sel3_shows_ch0", d, disp(0, 1));

`ifdef EGG_PRESET_EN
        sel = 2'd0;
        preset = 2'd2;
        pulse_cmd(5);
        read_disp(d);
        chk("preset_hard", d, disp(13, 0));
`endif

        // Display of ch1 running near 12:34: scan order, digits, dp on minute-ones only
        sel = 2'd1;
        repeat (12) pulse_cmd(3);
        repeat (35) pulse_cmd(4);
        pulse_cmd(1);
        wait_ticks(1);
        snap    = tick_cnt;
        an_prev = an;
        tc_prev = tick_cnt;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_5MHz);
            if (an != an_prev) begin
                chk("scan_order", 32'(an), 32'(next_an(an_prev)));
                case (an)
                    8'hF7: chk("dig_m_tens", 32'(seg), 32'(seg7(1)));
                    8'hFB: chk("dig_m_ones_dp", 32'(seg), 32'(seg7(2) & 8'h7F));
                    8'hFD: chk("dig_s_tens", 32'(seg), 32'(seg7(3)));
                    8'hFE: chk("dig_s_ones", 32'(seg), 32'(seg7(4 - (tc_prev - snap))));
                    default: chk("an_legal", 32'(an), 32'hF7);
                endcase
            end
            an_prev = an;
            tc_prev = tick_cnt;
        end

        // Asynchronous reset while ch1 runs
        @(negedge clk_5MHz);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        chk("async_alarm", 32'(alarm), 32'h0);
        chk("async_an", 32'(an), 32'hFF);
        chk("async_seg", 32'(seg), 32'hFF);
        repeat (2) @(negedge clk_5MHz);
        reset = 1'b0;
        @(negedge clk_5MHz);
        chk("post_rst_busy", 32'(busy), 32'h0);
        read_disp(d);
        chk("post_rst_ch1_0000", d, disp(0, 0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
